// File: rtl/alu_wide_sequencer_pkg.sv
// Shared definitions for the wide ALU sequencer: execute-command codes,
// NZCV flag bit positions, the sequencer state encoding and the ALU word
// width. Imported by the interface, the carry generator and the top.
package alu_wide_sequencer_pkg;

  localparam int WORD_W = 32;

  // Execute-command codes; 4'b1010..4'b1111 are unsupported.
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_MOV = 4'd1;
  localparam logic [3:0] CMD_ADD = 4'd2;
  localparam logic [3:0] CMD_ADC = 4'd3;
  localparam logic [3:0] CMD_SUB = 4'd4;
  localparam logic [3:0] CMD_SBC = 4'd5;
  localparam logic [3:0] CMD_AND = 4'd6;
  localparam logic [3:0] CMD_ORR = 4'd7;
  localparam logic [3:0] CMD_EOR = 4'd8;
  localparam logic [3:0] CMD_MVN = 4'd9;

  // Flag bit positions inside a {N,Z,C,V} nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_unsupported(input logic [3:0] cmd);
    return cmd > CMD_MVN;
  endfunction

  function automatic logic is_sub(input logic [3:0] cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_SBC);
  endfunction

  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_ADC) || is_sub(cmd);
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// Bundle of the request channel, response channel and word-wide ALU port
// of the wide ALU sequencer.
//   req_*  : requester -> sequencer (req_ready flows back)
//   rsp_*  : sequencer -> consumer  (rsp_ready flows back)
//   alu_*  : sequencer <-> external 32-bit ALU (combinational path)
// Handshake: a transfer occurs on a rising clk edge where valid and ready
// are both high. Once valid is raised its payload stays stable until that
// edge; ready never depends on valid.
// Modports: slave = the sequencer, master = requester/consumer/ALU side.
interface alu_wide_sequencer_if
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 2
);
  localparam int W = WORD_W * NUM_WORDS;

  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_cmd;
  logic [W-1:0]         req_op1;
  logic [W-1:0]         req_op2;
  logic [3:0]           req_flags_in;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W-1:0]         rsp_result;
  logic [3:0]           rsp_flags;
  logic                 rsp_err;

  logic [WORD_W-1:0]    alu_in_1;
  logic [WORD_W-1:0]    alu_in_2;
  logic [3:0]           alu_cmd;
  logic [3:0]           alu_status_in;
  logic [WORD_W-1:0]    alu_result;
  logic [3:0]           alu_status_out;

  modport slave (
    input  req_valid, req_cmd, req_op1, req_op2, req_flags_in,
    output req_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready,
    output alu_in_1, alu_in_2, alu_cmd, alu_status_in,
    input  alu_result, alu_status_out
  );

  modport master (
    output req_valid, req_cmd, req_op1, req_op2, req_flags_in,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    output rsp_ready,
    input  alu_in_1, alu_in_2, alu_cmd, alu_status_in,
    output alu_result, alu_status_out
  );

endinterface

// File: rtl/alu_wide_sequencer_carry_gen.sv
// Per-word carry/borrow generator for the wide ALU sequencer.
// Ports:
//   a_i, b_i : word operands
//   cin_i    : carry into this word (C=1 means "no borrow" for subtract)
//   sub_i    : 1 = subtract (a + ~b + cin), 0 = add (a + b + cin)
//   cout_o   : carry out of bit 31
//   v_o      : signed overflow of this word, meaningful for the top word
module alu_wide_sequencer_carry_gen
  import alu_wide_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  input  logic              sub_i,
  output logic              cout_o,
  output logic              v_o
);
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W:0]   sum;

  always_comb begin
    b_eff  = sub_i ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WORD_W{1'b0}}, cin_i};
    cout_o = sum[WORD_W];
    // With b inverted for subtract, a31 != b31 becomes a31 == b_eff31,
    // so one expression covers both add and subtract overflow.
    v_o    = (a_i[WORD_W-1] == b_eff[WORD_W-1]) &&
             (sum[WORD_W-1] != a_i[WORD_W-1]);
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Wide ALU sequencer: accepts one NUM_WORDS x 32-bit operation, runs it
// through the external 32-bit ALU one word per cycle (low word first),
// builds the inter-word carry chain and final NZCV flags locally, and
// returns the wide result on the response channel.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request/response/ALU bundle (slave side)
//   dbg_state_o  : current state (IDLE/RUN/DONE encoding of state_t)
//   dbg_k_o      : current word index
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_wide_sequencer_if.slave        bus,
  output logic [1:0]                 dbg_state_o,
  output logic [1:0]                 dbg_k_o
);
  localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] wide_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [3:0]      cmd_q, cmd_d;
  wide_t           op1_q, op1_d;
  wide_t           op2_q, op2_d;
  wide_t           res_q, res_d;
  logic [3:0]      fin_q, fin_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic [3:0]      flags_q, flags_d;
  logic            err_q, err_d;

  logic [WORD_W-1:0] a_w, b_w;
  logic              cg_cout, cg_v;
  logic              cmd_err, cmd_nop, z_now;

  assign a_w     = op1_q[k_q];
  assign b_w     = op2_q[k_q];
  assign cmd_err = is_unsupported(cmd_q);
  assign cmd_nop = (cmd_q == CMD_NOP);
  assign z_now   = zacc_q & bus.alu_status_out[FLAG_Z];

  alu_wide_sequencer_carry_gen u_carry_gen (
    .a_i    (a_w),
    .b_i    (b_w),
    .cin_i  (carry_q),
    .sub_i  (is_sub(cmd_q)),
    .cout_o (cg_cout),
    .v_o    (cg_v)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    fin_d   = fin_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    flags_d = flags_q;
    err_d   = err_q;

    bus.req_ready     = (state_q == ST_IDLE) && !rst;
    bus.rsp_valid     = (state_q == ST_DONE);
    bus.alu_cmd       = CMD_NOP;
    bus.alu_in_1      = '0;
    bus.alu_in_2      = '0;
    bus.alu_status_in = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cmd_d   = bus.req_cmd;
          op1_d   = bus.req_op1;
          op2_d   = bus.req_op2;
          fin_d   = bus.req_flags_in;
          k_d     = '0;
          zacc_d  = 1'b1;
          state_d = ST_RUN;
          // c_0: 0 for ADD, 1 for SUB (no borrow), incoming C for ADC/SBC.
          unique case (bus.req_cmd)
            CMD_SUB:          carry_d = 1'b1;
            CMD_ADC, CMD_SBC: carry_d = bus.req_flags_in[FLAG_C];
            default:          carry_d = 1'b0;
          endcase
        end
      end

      ST_RUN: begin
        bus.alu_in_1      = a_w;
        bus.alu_in_2      = b_w;
        bus.alu_status_in = {fin_q[FLAG_N], fin_q[FLAG_Z], carry_q, fin_q[FLAG_V]};
        if (cmd_err)
          bus.alu_cmd = CMD_NOP;
        else if (k_q != '0 && (cmd_q == CMD_ADD || cmd_q == CMD_ADC))
          bus.alu_cmd = CMD_ADC;
        else if (k_q != '0 && is_sub(cmd_q))
          bus.alu_cmd = CMD_SBC;
        else
          bus.alu_cmd = cmd_q;

        res_d[k_q] = (cmd_err || cmd_nop) ? '0 : bus.alu_result;
        zacc_d     = z_now;
        carry_d    = cg_cout;
        k_d        = k_q + 1'b1;

        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DONE;
          err_d   = cmd_err;
          if (cmd_err || cmd_nop)
            flags_d = fin_q;
          else if (is_arith(cmd_q))
            flags_d = {bus.alu_result[WORD_W-1], z_now, cg_cout, cg_v};
          else
            flags_d = {bus.alu_result[WORD_W-1], z_now, fin_q[FLAG_C], fin_q[FLAG_V]};
        end
      end

      ST_DONE: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      fin_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;
  assign dbg_state_o    = state_q;
  assign dbg_k_o        = 2'(k_q);

endmodule
